isqrt_rr_sched: RTL and testbench

Round-robin scheduler that shares one pipelined integer square-root unit (`isqrt`) between `N_REQ` independent requesters. Each requester presents a 32-bit operand with a valid/ready handshake. The scheduler issues at most one operand per cycle into the shared `isqrt` pipeline and tags it with the requester index. It then routes each result back to its owner at a fixed latency. It sits beside a single `isqrt` instance in formula datapaths where replicating the root unit per operand costs too much area.

---
 rtl/isqrt_sched_pkg.sv | 16 +
 rtl/isqrt_rr_sched_if.sv | 33 +++
 rtl/isqrt_tag_pipe.sv | 46 ++++
 rtl/isqrt_rr_sched.sv | 144 ++++++++++++++
 tb/tb_isqrt_rr_sched.sv | 348 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/isqrt_sched_pkg.sv
// Shared types and widths for the round-robin isqrt scheduler.
// Holds the operand width, the requester limit, the requester tag type
// and the tag-pipe slot payload.
package isqrt_sched_pkg;

  localparam int unsigned ISQRT_W = 32;
  localparam int unsigned MAX_REQ = 8;

  typedef logic [$clog2(MAX_REQ)-1:0] req_tag_t;

  typedef struct packed {
    logic     vld;
    req_tag_t tag;
  } tag_slot_t;

endpackage : isqrt_sched_pkg

// File: rtl/isqrt_rr_sched_if.sv
// Requester-side bundle of the isqrt scheduler.
//   req_vld / req_x / req_rdy : per-requester operand handshake
//   rsp_vld / rsp_y           : per-requester result strobe, shared result bus
// master = requesters, slave = scheduler.
interface isqrt_rr_sched_if
  import isqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ = 3
);

  logic [N_REQ-1:0]              req_vld;
  logic [N_REQ-1:0][ISQRT_W-1:0] req_x;
  logic [N_REQ-1:0]              req_rdy;
  logic [N_REQ-1:0]              rsp_vld;
  logic [ISQRT_W-1:0]            rsp_y;

  modport master (
    output req_vld,
    output req_x,
    input  req_rdy,
    input  rsp_vld,
    input  rsp_y
  );

  modport slave (
    input  req_vld,
    input  req_x,
    output req_rdy,
    output rsp_vld,
    output rsp_y
  );

endinterface : isqrt_rr_sched_if

// File: rtl/isqrt_tag_pipe.sv
// Fixed-depth delay line for requester tags, running in lockstep with the
// shared isqrt pipeline.
//   clk, rst_n : clock, async active-low reset (clears all slots)
//   din        : slot entering the pipe this cycle
//   dout       : slot leaving the pipe, DEPTH cycles after entry
// Valid bits always shift; tag bits only load behind a valid slot so idle
// cycles do not toggle the tag registers.
module isqrt_tag_pipe
  import isqrt_sched_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  input  tag_slot_t din,
  output tag_slot_t dout
);

  logic [DEPTH-1:0] vld_q;
  req_tag_t         tag_q [DEPTH];

  // Shift stage i-1 into stage i; stage 0 takes din.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= din.vld;
      if (din.vld) begin
        tag_q[0] <= din.tag;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) begin
          tag_q[i] <= tag_q[i-1];
        end
      end
    end
  end

  assign dout.vld = vld_q[DEPTH-1];
  assign dout.tag = tag_q[DEPTH-1];

endmodule : isqrt_tag_pipe

// File: rtl/isqrt_rr_sched.sv
// Round-robin scheduler sharing one pipelined isqrt unit between N_REQ
// requesters. Accepts at most one operand per cycle, tags it with the
// requester index and routes the result back ISQRT_LAT+2 cycles later.
//   clk, rst_n         : clock, async active-low reset
//   req_if (slave)     : req_vld/req_x/req_rdy handshake, rsp_vld/rsp_y results
//   sq_x_vld, sq_x     : registered operand issue to isqrt
//   sq_y_vld, sq_y     : isqrt result
//   err                : sticky tag/valid mismatch flag
// Build option: ISQRT_RR_SCHED_CHECK_EN enables the mismatch check; when
// undefined err is tied low.
module isqrt_rr_sched
  import isqrt_sched_pkg::*;
#(
  parameter int unsigned N_REQ     = 3,
  parameter int unsigned ISQRT_LAT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  isqrt_rr_sched_if.slave    req_if,
  output logic               sq_x_vld,
  output logic [ISQRT_W-1:0] sq_x,
  input  logic               sq_y_vld,
  input  logic [ISQRT_W-1:0] sq_y,
  output logic               err
);

  req_tag_t           ptr;
  req_tag_t           issue_tag;
  req_tag_t           lo_c;
  req_tag_t           hi_c;
  req_tag_t           gnt_c;
  logic               any_c;
  logic               hi_found_c;
  logic               xfer_c;
  logic [N_REQ-1:0]   rdy_c;
  logic [ISQRT_W-1:0] gnt_x_c;
  logic [N_REQ-1:0]   rsp_nxt_c;
  logic [N_REQ-1:0]   rsp_vld_q;
  logic [ISQRT_W-1:0] rsp_y_q;
  tag_slot_t          tag_in;
  tag_slot_t          tag_out;

  // Round-robin pick: lowest requester at or above ptr, else lowest overall.
  always_comb begin
    lo_c       = '0;
    hi_c       = '0;
    any_c      = 1'b0;
    hi_found_c = 1'b0;
    for (int j = int'(N_REQ) - 1; j >= 0; j--) begin
      if (req_if.req_vld[j]) begin
        any_c = 1'b1;
        lo_c  = req_tag_t'(j);
        if (j >= int'(ptr)) begin
          hi_found_c = 1'b1;
          hi_c       = req_tag_t'(j);
        end
      end
    end
    gnt_c = hi_found_c ? hi_c : lo_c;
  end

  // Grant decode and operand select; rdy is held low while in reset.
  always_comb begin
    rdy_c   = '0;
    gnt_x_c = '0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      if (int'(gnt_c) == j) begin
        rdy_c[j] = any_c & rst_n;
        gnt_x_c  = req_if.req_x[j];
      end
    end
  end

  assign xfer_c         = any_c & rst_n;
  assign req_if.req_rdy = rdy_c;

  // Issue register; sq_x and the tag hold on idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      sq_x_vld  <= 1'b0;
      sq_x      <= '0;
      issue_tag <= '0;
    end else begin
      sq_x_vld <= xfer_c;
      if (xfer_c) begin
        sq_x      <= gnt_x_c;
        issue_tag <= gnt_c;
        ptr       <= (int'(gnt_c) == int'(N_REQ) - 1) ? '0 : gnt_c + req_tag_t'(1);
      end
    end
  end

  assign tag_in.vld = sq_x_vld;
  assign tag_in.tag = issue_tag;

  isqrt_tag_pipe #(
    .DEPTH (ISQRT_LAT)
  ) u_tag_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (tag_in),
    .dout  (tag_out)
  );

  // Response demux: the owner is whatever tag leaves the pipe with sq_y_vld.
  always_comb begin
    rsp_nxt_c = '0;
    for (int j = 0; j < int'(N_REQ); j++) begin
      rsp_nxt_c[j] = sq_y_vld && (int'(tag_out.tag) == j);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_vld_q <= '0;
      rsp_y_q   <= '0;
    end else begin
      rsp_vld_q <= rsp_nxt_c;
      if (sq_y_vld) begin
        rsp_y_q <= sq_y;
      end
    end
  end

  assign req_if.rsp_vld = rsp_vld_q;
  assign req_if.rsp_y   = rsp_y_q;

`ifdef ISQRT_RR_SCHED_CHECK_EN
  // Sticky flag when the isqrt valid disagrees with the tag pipe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (sq_y_vld != tag_out.vld) begin
      err <= 1'b1;
    end
  end
`else
  logic unused_tag_vld;
  assign unused_tag_vld = tag_out.vld;
  assign err            = 1'b0;
`endif

endmodule : isqrt_rr_sched

// File: tb/tb_isqrt_rr_sched.sv
// Directed self-checking bench for isqrt_rr_sched with a behavioural
// ISQRT_LAT-deep isqrt model attached.
module tb_isqrt_rr_sched;

  localparam int unsigned N_REQ = 3;
  localparam int unsigned LAT   = 16;
`ifdef ISQRT_RR_SCHED_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        sq_x_vld;
  logic [31:0] sq_x;
  logic        sq_y_vld;
  logic [31:0] sq_y;
  logic        err;
  logic        force_y;
  int          cyc;
  int          checks;
  int          fails;

  isqrt_rr_sched_if #(.N_REQ(N_REQ)) rif ();

  isqrt_rr_sched #(
    .N_REQ     (N_REQ),
    .ISQRT_LAT (LAT)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_if   (rif.slave),
    .sq_x_vld (sq_x_vld),
    .sq_x     (sq_x),
    .sq_y_vld (sq_y_vld),
    .sq_y     (sq_y),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ref_sqrt(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (64'(t) * 64'(t) <= 64'(x)) r = t;
    end
    return r;
  endfunction

  // Behavioural isqrt: LAT cycles from sq_x_vld to sq_y_vld, shares reset.
  logic [LAT-1:0] m_vld;
  logic [31:0]    m_y [LAT];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_vld <= '0;
      for (int i = 0; i < int'(LAT); i++) m_y[i] <= '0;
    end else begin
      m_vld <= {m_vld[LAT-2:0], sq_x_vld};
      m_y[0] <= ref_sqrt(sq_x);
      for (int i = 1; i < int'(LAT); i++) m_y[i] <= m_y[i-1];
    end
  end
  assign sq_y_vld = m_vld[LAT-1] | force_y;
  assign sq_y     = m_y[LAT-1];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rif.req_vld = '0;
    force_y     = 1'b0;
    rst_n       = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n       = 1'b0;
    force_y     = 1'b0;
    rif.req_vld = 3'b111;
    rif.req_x   = '{32'd7, 32'd8, 32'd9};
    tick();
    tick();
    checks++;
    if (rif.req_rdy !== 3'b000 || rif.rsp_vld !== 3'b000 || rif.rsp_y !== 32'd0 ||
        sq_x_vld !== 1'b0 || sq_x !== 32'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b rsp_vld=%b rsp_y=%0d sq_x_vld=%b sq_x=%0d err=%b, want all 0",
               rif.req_rdy, rif.rsp_vld, rif.rsp_y, sq_x_vld, sq_x, err);
    end
    rif.req_vld = '0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int  t0;
    int  got_cyc;
    bit  seen;
    logic [2:0]  got_vld;
    logic [31:0] got_y;
    do_reset();
    rif.req_x[1] = 32'd144;
    rif.req_vld  = 3'b010;
    #3;
    t0 = cyc;
    checks++;
    if (rif.req_rdy !== 3'b010) begin
      fails++;
      $display("FAIL single_rdy: got %b want 010", rif.req_rdy);
    end
    tick();
    rif.req_vld = '0;
    checks++;
    if (sq_x_vld !== 1'b1 || sq_x !== 32'd144) begin
      fails++;
      $display("FAIL single_issue: sq_x_vld=%b sq_x=%0d want 1/144", sq_x_vld, sq_x);
    end
    tick();
    checks++;
    if (sq_x_vld !== 1'b0 || sq_x !== 32'd144) begin
      fails++;
      $display("FAIL single_idle_hold: sq_x_vld=%b sq_x=%0d want 0/144", sq_x_vld, sq_x);
    end
    seen = 1'b0;
    got_cyc = 0;
    got_vld = '0;
    got_y = '0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (rif.rsp_vld !== 3'b000) begin
        seen = 1'b1;
        got_cyc = cyc;
        got_vld = rif.rsp_vld;
        got_y = rif.rsp_y;
      end
    end
    checks++;
    if (!seen || got_cyc - t0 != int'(LAT) + 2) begin
      fails++;
      $display("FAIL single_latency: seen=%b latency=%0d want %0d", seen, got_cyc - t0, LAT + 2);
    end
    checks++;
    if (got_vld !== 3'b010 || got_y !== 32'd12) begin
      fails++;
      $display("FAIL single_result: rsp_vld=%b rsp_y=%0d want 010/12", got_vld, got_y);
    end
  endtask

  task automatic test_contention();
    int          t0;
    logic [2:0]  exp_oh;
    logic [2:0]  q_vld [$];
    logic [31:0] q_y [$];
    int          q_cyc [$];
    do_reset();
    t0 = 0;
    rif.req_x   = '{32'd16, 32'd9, 32'd4};
    rif.req_vld = 3'b111;
    for (int i = 0; i < 9; i++) begin
      #3;
      if (i == 0) t0 = cyc;
      exp_oh = 3'(1 << (i % 3));
      checks++;
      if (rif.req_rdy !== exp_oh) begin
        fails++;
        $display("FAIL contention_grant[%0d]: got %b want %b", i, rif.req_rdy, exp_oh);
      end
      tick();
    end
    rif.req_vld = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rif.rsp_vld !== 3'b000) begin
        q_vld.push_back(rif.rsp_vld);
        q_y.push_back(rif.rsp_y);
        q_cyc.push_back(cyc);
      end
    end
    checks++;
    if (q_vld.size() != 9) begin
      fails++;
      $display("FAIL contention_count: got %0d responses want 9", q_vld.size());
    end
    for (int i = 0; i < q_vld.size() && i < 9; i++) begin
      exp_oh = 3'(1 << (i % 3));
      checks++;
      if (q_vld[i] !== exp_oh || q_y[i] !== 32'(i % 3 + 2) || q_cyc[i] != t0 + int'(LAT) + 2 + i) begin
        fails++;
        $display("FAIL contention_rsp[%0d]: vld=%b y=%0d cyc=%0d want %b/%0d/%0d",
                 i, q_vld[i], q_y[i], q_cyc[i] - t0, exp_oh, i % 3 + 2, LAT + 2 + i);
      end
    end
  endtask

  task automatic test_wrap_skip();
    logic [2:0] exp_seq [3];
    exp_seq = '{3'b001, 3'b010, 3'b001};
    do_reset();
    // Single grant on requester 1 leaves ptr at 2.
    rif.req_x   = '{32'd1, 32'd1, 32'd1};
    rif.req_vld = 3'b010;
    tick();
    rif.req_vld = 3'b011;
    for (int i = 0; i < 3; i++) begin
      #3;
      checks++;
      if (rif.req_rdy !== exp_seq[i]) begin
        fails++;
        $display("FAIL wrap_grant[%0d]: got %b want %b", i, rif.req_rdy, exp_seq[i]);
      end
      tick();
    end
    rif.req_vld = '0;
  endtask

  task automatic test_back_to_back();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [2:0]  q_vld [$];
    logic [31:0] q_y [$];
    int          q_cyc [$];
    xs = '{32'd0, 32'd1, 32'hFFFF_FFFF};
    ys = '{32'd0, 32'd1, 32'd65535};
    do_reset();
    rif.req_vld = 3'b100;
    for (int i = 0; i < 3; i++) begin
      rif.req_x[2] = xs[i];
      #3;
      checks++;
      if (rif.req_rdy !== 3'b100) begin
        fails++;
        $display("FAIL b2b_rdy[%0d]: got %b want 100", i, rif.req_rdy);
      end
      tick();
    end
    rif.req_vld = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (rif.rsp_vld !== 3'b000) begin
        q_vld.push_back(rif.rsp_vld);
        q_y.push_back(rif.rsp_y);
        q_cyc.push_back(cyc);
      end
    end
    checks++;
    if (q_vld.size() != 3) begin
      fails++;
      $display("FAIL b2b_count: got %0d responses want 3", q_vld.size());
    end
    for (int i = 0; i < q_vld.size() && i < 3; i++) begin
      checks++;
      if (q_vld[i] !== 3'b100 || q_y[i] !== ys[i] || q_cyc[i] != q_cyc[0] + i) begin
        fails++;
        $display("FAIL b2b_rsp[%0d]: vld=%b y=%0d offset=%0d want 100/%0d/%0d",
                 i, q_vld[i], q_y[i], q_cyc[i] - q_cyc[0], ys[i], i);
      end
    end
  endtask

  task automatic test_reset_midflight();
    int n_bad;
    do_reset();
    rif.req_x   = '{32'd16, 32'd9, 32'd4};
    rif.req_vld = 3'b111;
    for (int i = 0; i < 3; i++) tick();
    rif.req_vld = '0;
    for (int i = 0; i < 5; i++) tick();
    rif.req_vld = 3'b111;
    rst_n = 1'b0;
    #1;
    checks++;
    if (rif.req_rdy !== 3'b000 || rif.rsp_vld !== 3'b000 || rif.rsp_y !== 32'd0 ||
        sq_x_vld !== 1'b0 || sq_x !== 32'd0 || err !== 1'b0) begin
      fails++;
      $display("FAIL midflight_clear: rdy=%b rsp_vld=%b rsp_y=%0d sq_x_vld=%b sq_x=%0d err=%b, want all 0",
               rif.req_rdy, rif.rsp_vld, rif.rsp_y, sq_x_vld, sq_x, err);
    end
    tick();
    rif.req_vld = '0;
    rst_n = 1'b1;
    n_bad = 0;
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (rif.rsp_vld !== 3'b000 || err !== 1'b0) n_bad++;
    end
    checks++;
    if (n_bad != 0) begin
      fails++;
      $display("FAIL midflight_dropped: %0d cycles with rsp_vld or err set, want 0", n_bad);
    end
  endtask

  task automatic test_check_err();
    do_reset();
    force_y = 1'b1;
    tick();
    force_y = 1'b0;
    checks++;
    if (err !== EXP_ERR) begin
      fails++;
      $display("FAIL err_set: got %b want %b", err, EXP_ERR);
    end
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (err !== EXP_ERR) begin
      fails++;
      $display("FAIL err_sticky: got %b want %b", err, EXP_ERR);
    end
    do_reset();
    tick();
    checks++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_cleared: got %b want 0", err);
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    force_y = 1'b0;
    rif.req_vld = '0;
    rif.req_x   = '0;
    test_reset();
    test_single();
    test_contention();
    test_wrap_skip();
    test_back_to_back();
    test_reset_midflight();
    test_check_err();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_isqrt_rr_sched
